bin_to_bcd_seq: RTL

- Sequential double-dabble converter. Turns the binary display value (e.g. 0–127 from the counter/score logic) into packed BCD digits.
- Sits directly upstream of the seven-segment scan/decoder stage, which selects one nibble per anode slot.
- Uses a start/busy/done handshake. Outputs hold stable between conversions so the scanned display never shows a partial result.

---
 rtl/bin_to_bcd_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq -- sequential double-dabble binary-to-BCD converter.
//
// Converts a BIN_W-bit binary value into DIGITS packed BCD nibbles, one
// double-dabble step per clock. It feeds the seven-segment scan stage.
// bcd_out/blank_out only change on the done edge, so the display never
// shows a partial result.
//
// Optional feature: define BCD_BLANK_LEADING_EN to generate the
// leading-zero blank mask on blank_out. Without it, blank_out is tied to 0.
//
// Ports:
//   clk       in   system clock, posedge
//   reset     in   synchronous active-high reset
//   start     in   conversion request, sampled only while busy=0
//   bin_in    in   [BIN_W] binary value, captured on the accept edge
//   busy      out  high from the accept edge through the done cycle
//   done      out  one-cycle pulse, bcd_out freshly updated
//   bcd_out   out  [4*DIGITS] packed BCD, digit 0 (ones) in [3:0]
//   blank_out out  [DIGITS] leading-zero blank mask (bit 0 always 0)
module bin_to_bcd_seq #(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out
);

  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state, state_nxt;
  logic [BIN_W-1:0]         shreg, shreg_nxt;
  logic [DIGITS-1:0][3:0]   scratch, scratch_nxt;
  logic [DIGITS-1:0][3:0]   adj;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic                     done_nxt;
  logic                     load_out;
  logic [4*DIGITS-1:0]      bcd_r;

  // Nibble correction: every digit is tested on its pre-add value, in
  // parallel, before the shift of this step.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      if (scratch[i] >= 4'd5) adj[i] = scratch[i] + 4'd3;
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    scratch_nxt = scratch;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    load_out    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt   = bin_in;
          scratch_nxt = '0;
          cnt_nxt     = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
        cnt_nxt = cnt + 1'b1;
        // Last step: the shifted scratch is the final result.
        if (cnt == CW'(BIN_W - 1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          load_out  = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bcd_r   <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      scratch <= scratch_nxt;
      cnt     <= cnt_nxt;
      done    <= done_nxt;
      if (load_out) bcd_r <= scratch_nxt;
    end
  end

  assign busy    = (state != IDLE);
  assign bcd_out = bcd_r;

`ifdef BCD_BLANK_LEADING_EN
  logic [DIGITS-1:0] blank_nxt, blank_r;
  logic              all_zero;

  // Walk from the top digit down; a digit is blanked while it and
  // everything above it is zero. The ones digit is never blanked.
  always_comb begin
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero & (scratch_nxt[i] == 4'd0);
      blank_nxt[i] = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         blank_r <= '0;
    else if (load_out) blank_r <= blank_nxt;
  end

  assign blank_out = blank_r;
`else
  assign blank_out = '0;
`endif

endmodule
